// File: rtl/store_write_buffer.sv
// Posted-write FIFO between store alignment and byte-writable data memory, with load-hazard detection.
// Latency: a push is visible on mem_wr_en the next cycle (no bypass); ld_hazard is combinational.
// Backpressure: st_ready drops only when DEPTH entries are held, regardless of a same-cycle pop.
//
// Ports:
//   clk, rst_n                          clock (rising edge), asynchronous active-low reset
//   st_valid/st_ready/st_addr/
//   st_wmask/st_wdata                   store request from the alignment stage
//   mem_wr_en/mem_addr/mem_wmask/
//   mem_wdata/mem_wr_ack                head entry presented to memory, popped on ack
//   ld_valid/ld_addr/ld_hazard          load word-address hazard check
//   empty/count                         occupancy status (registered)
module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [3:0]               st_wmask,
  input  logic [31:0]              st_wdata,
  output logic                     mem_wr_en,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [3:0]               mem_wmask,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_wr_ack,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hazard,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int WA_W = ADDR_W - 2;

  // Entry storage: word address, byte mask, data, plus a per-slot valid bit
  // so the hazard compare only looks at slots that are really held.
  logic [WA_W-1:0]  ent_waddr [DEPTH];
  logic [3:0]       ent_mask  [DEPTH];
  logic [31:0]      ent_data  [DEPTH];
  logic [DEPTH-1:0] ent_vld;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;

  logic             accept;
  logic             push;
  logic             pop;
  logic             held_hit;
  logic             incoming_hit;

  // Byte-offset bits never matter: everything is tracked per word.
  logic             unused_lsbs;
  assign unused_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  assign st_ready  = (count_q != CW'(DEPTH));
  assign accept    = st_valid && st_ready;
  // A zero-mask store completes its handshake but writes nothing, so it is dropped.
  assign push      = accept && (st_wmask != 4'b0000);
  assign mem_wr_en = (count_q != '0);
  assign pop       = mem_wr_en && mem_wr_ack;

  assign empty     = (count_q == '0);
  assign count     = count_q;

  // Head outputs are forced to zero when nothing is held so stale slot
  // contents never leak onto the memory bus.
  assign mem_addr  = mem_wr_en ? {ent_waddr[rd_ptr], 2'b00} : '0;
  assign mem_wmask = mem_wr_en ? ent_mask[rd_ptr]           : 4'b0000;
  assign mem_wdata = mem_wr_en ? ent_data[rd_ptr]           : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ent_vld <= '0;
    end else begin
      // Push and pop never target the same slot: that needs wr_ptr == rd_ptr,
      // i.e. empty (no pop) or full (no push).
      if (pop) begin
        rd_ptr          <= rd_ptr + PW'(1);
        ent_vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr          <= wr_ptr + PW'(1);
        ent_vld[wr_ptr] <= 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Payload needs no reset: it is only observed through ent_vld / count.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_waddr[wr_ptr] <= st_addr[ADDR_W-1:2];
      ent_mask[wr_ptr]  <= st_wmask;
      ent_data[wr_ptr]  <= st_wdata;
    end
  end

  // Word match against every held entry (including one popping this cycle)
  // and against a store being enqueued in this same cycle.
  always_comb begin
    held_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_waddr[i] == ld_addr[ADDR_W-1:2])) begin
        held_hit = 1'b1;
      end
    end
  end

  assign incoming_hit = push && (st_addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
  assign ld_hazard    = ld_valid && (held_hit || incoming_hit);

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [3:0]  st_wmask;
  logic [31:0] st_wdata;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_wr_ack;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        empty;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  int nwrites = 0;

  store_write_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_wmask   (st_wmask),
    .st_wdata   (st_wdata),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_wr_ack (mem_wr_ack),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_hazard  (ld_hazard),
    .empty      (empty),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every write the memory actually takes.
  always @(posedge clk) begin
    if (rst_n && mem_wr_en && mem_wr_ack) nwrites++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic v, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    st_valid = v;
    st_addr  = a;
    st_wmask = m;
    st_wdata = d;
  endtask

  initial begin
    logic [31:0] exp_a [4];

    rst_n = 1'b0;
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    mem_wr_ack = 1'b0;
    ld_valid   = 1'b1;
    ld_addr    = 32'h0;
    #2;
    check("rst_empty",   empty, 1);
    check("rst_ready",   st_ready, 1);
    check("rst_wr_en",   mem_wr_en, 0);
    check("rst_addr",    mem_addr, 0);
    check("rst_mask",    mem_wmask, 0);
    check("rst_data",    mem_wdata, 0);
    check("rst_count",   count, 0);
    check("rst_hazard",  ld_hazard, 0);
    #10 rst_n = 1'b1;
    ld_valid = 1'b0;
    tick();

    // Single store, held while ack is low, then drained.
    set_store(1'b1, 32'h104, 4'b0011, 32'h0000BEEF);
    #1;
    check("t1_ready", st_ready, 1);
    check("t1_nobypass", mem_wr_en, 0);
    tick();
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    check("t1_wr_en", mem_wr_en, 1);
    check("t1_addr",  mem_addr, 32'h104);
    check("t1_mask",  mem_wmask, 4'b0011);
    check("t1_data",  mem_wdata, 32'h0000BEEF);
    check("t1_count", count, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_hold_en",   mem_wr_en, 1);
      check("t1_hold_addr", mem_addr, 32'h104);
      check("t1_hold_data", mem_wdata, 32'h0000BEEF);
    end
    mem_wr_ack = 1'b1;
    tick();
    mem_wr_ack = 1'b0;
    #1;
    check("t1_empty", empty, 1);
    check("t1_off",   mem_wr_en, 0);
    check("t1_zaddr", mem_addr, 0);
    check("t1_zmask", mem_wmask, 0);
    check("t1_zdata", mem_wdata, 0);

    // Fill to DEPTH, refuse a fifth, drain in order.
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 32'h1000 + 32'(4*i), 4'hF, 32'hA0 + 32'(i));
      tick();
    end
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    check("t2_count4", count, 4);
    check("t2_full_ready", st_ready, 0);
    set_store(1'b1, 32'h2000, 4'hF, 32'hDEAD);
    #1;
    check("t2_fifth_ready", st_ready, 0);
    tick();
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    check("t2_fifth_count", count, 4);
    mem_wr_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_order_addr", mem_addr, 32'h1000 + 32'(4*i));
      check("t2_order_data", mem_wdata, 32'hA0 + 32'(i));
      tick();
      if (i == 0) check("t2_ready_after_pop", st_ready, 1);
    end
    mem_wr_ack = 1'b0;
    #1;
    check("t2_empty", empty, 1);

    // Full with simultaneous store and ack: store refused, accepted next cycle.
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 32'h3000 + 32'(4*i), 4'hF, 32'hB0 + 32'(i));
      tick();
    end
    set_store(1'b1, 32'h4000, 4'hF, 32'h55);
    mem_wr_ack = 1'b1;
    #1;
    check("t3_full_ack_ready", st_ready, 0);
    tick();
    mem_wr_ack = 1'b0;
    #1;
    check("t3_count3", count, 3);
    check("t3_ready", st_ready, 1);
    tick();
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    check("t3_count4", count, 4);
    exp_a[0] = 32'h3004; exp_a[1] = 32'h3008; exp_a[2] = 32'h300C; exp_a[3] = 32'h4000;
    mem_wr_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_order_addr", mem_addr, exp_a[i]);
      tick();
    end
    mem_wr_ack = 1'b0;
    #1;
    check("t3_empty", empty, 1);

    // Load hazards.
    set_store(1'b1, 32'h200, 4'b1000, 32'h11000000);
    tick();
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    ld_valid = 1'b1;
    ld_addr  = 32'h201;
    #1;
    check("t4_hit_same_word", ld_hazard, 1);
    ld_addr = 32'h204;
    #1;
    check("t4_next_word", ld_hazard, 0);
    ld_valid = 1'b0;
    ld_addr  = 32'h201;
    #1;
    check("t4_ld_invalid", ld_hazard, 0);
    ld_valid = 1'b1;
    ld_addr  = 32'h302;
    set_store(1'b1, 32'h300, 4'b0001, 32'h77);
    #1;
    check("t4_incoming_hit", ld_hazard, 1);
    st_wmask = 4'b0000;
    #1;
    check("t4_incoming_zero_mask", ld_hazard, 0);
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    ld_addr    = 32'h203;
    mem_wr_ack = 1'b1;
    #1;
    check("t4_popping_hit", ld_hazard, 1);
    tick();
    mem_wr_ack = 1'b0;
    ld_valid   = 1'b0;
    #1;
    check("t4_empty", empty, 1);

    // Streaming push/pop through pointer wrap.
    mem_wr_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_store(1'b1, 32'h5000 + 32'(4*i), 4'hF, 32'hC0 + 32'(i));
      tick();
      check("t5_count", count, 1);
      check("t5_addr",  mem_addr, 32'h5000 + 32'(4*i));
      check("t5_data",  mem_wdata, 32'hC0 + 32'(i));
    end
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    mem_wr_ack = 1'b0;
    #1;
    check("t5_empty", empty, 1);

    // Zero-mask store: handshake only.
    set_store(1'b1, 32'h6000, 4'b0000, 32'hFFFF);
    #1;
    check("t5_zm_ready", st_ready, 1);
    tick();
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    check("t5_zm_count", count, 0);
    check("t5_zm_noreq", mem_wr_en, 0);

    // Asynchronous reset with entries held.
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 32'h7000 + 32'(4*i), 4'hF, 32'hE0 + 32'(i));
      tick();
    end
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    check("t6_count3", count, 3);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_wr_en", mem_wr_en, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_ready", st_ready, 1);
    #1;
    rst_n = 1'b1;
    mem_wr_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_write", mem_wr_en, 0);
    end
    mem_wr_ack = 1'b0;
    tick();
    check("total_writes", nwrites, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Posted-write FIFO between the store-alignment stage (byte mask + lane-shifted write data) and the byte-writable data memory.
- Accepts aligned stores in one cycle and drains them to memory under a valid/ack handshake, so store-side stalls are decoupled from memory latency.
- Flags loads that hit a word with a pending store, so the pipeline can stall until that store drains.

Parameters:
DEPTH, 4, number of buffered stores; power of two, >= 2
ADDR_W, 32, byte-address width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
st_valid  input  1  store request from alignment stage
st_ready  output  1  buffer can accept a store
st_addr  input  ADDR_W  store byte address
st_wmask  input  4  byte-lane write mask
st_wdata  input  32  lane-aligned write data
mem_wr_en  output  1  head entry presented to memory
mem_addr  output  ADDR_W  word-aligned address of head entry
mem_wmask  output  4  byte mask of head entry
mem_wdata  output  32  data of head entry
mem_wr_ack  input  1  memory accepted presented write this cycle
ld_valid  input  1  load address valid
ld_addr  input  ADDR_W  load byte address
ld_hazard  output  1  load word matches a pending or incoming store
empty  output  1  no entries held
count  output  $clog2(DEPTH)+1  number of entries held

Behaviour:
Reset (rst_n low, asynchronous):
- Pointers and count clear immediately; all entries are invalidated.
- empty=1, st_ready=1, mem_wr_en=0, mem_addr/mem_wmask/mem_wdata=0, ld_hazard=0.
- Reset asserted mid-drain discards all entries. No write is guaranteed complete unless mem_wr_ack was sampled high before reset.

Storage and enqueue:
- Circular buffer with wr_ptr/rd_ptr modulo DEPTH; count tracks occupancy.
- st_ready = (count != DEPTH). It does not depend on same-cycle pop, so a full buffer refuses a store even if mem_wr_ack is high.
- A push occurs on st_valid && st_ready. The entry stored is {st_addr[ADDR_W-1:2], st_wmask, st_wdata}.
- A store with st_wmask == 4'b0000 is accepted (handshake completes) but not enqueued; count is unchanged.

Drain:
- mem_wr_en = (count != 0). mem_addr = {head word address, 2'b00}; mem_wmask and mem_wdata come from the head entry.
- When empty, mem_addr, mem_wmask and mem_wdata are forced to 0.
- A pop occurs on mem_wr_en && mem_wr_ack. mem_wr_ack is ignored when mem_wr_en=0.
- Head outputs stay stable while mem_wr_en=1 and mem_wr_ack=0.
- Drain order is strict FIFO; there is no coalescing.

Latency and simultaneity:
- A store pushed into an empty buffer appears on mem_wr_en in the next cycle. There is no combinational bypass.
- Simultaneous push and pop leaves count unchanged; both pointers advance.
- Pointers wrap from DEPTH-1 to 0.

Hazard (combinational):
- ld_hazard = ld_valid && (any held entry's word address == ld_addr[ADDR_W-1:2], OR (st_valid && st_ready && st_wmask != 0 && st_addr word == ld_addr word)).
- Byte overlap is not checked; a word match alone raises ld_hazard.
- An entry popped in the current cycle still counts toward ld_hazard in that cycle.

Status:
- empty = (count == 0). count is a registered value.

Test Plan:
- Reset, then a single store (addr=0x104, mask=0011, data=0x0000BEEF) with mem_wr_ack held 0 -> next cycle mem_wr_en=1, mem_addr=0x104, mask=0011, data=0x0000BEEF; outputs hold steady over 3 cycles; ack for one cycle -> empty=1, mem_* outputs = 0.
- Push 4 stores with ack=0 (DEPTH=4) -> count=4, st_ready=0; 5th st_valid is not accepted; ack every cycle -> memory sees the 4 writes in push order; st_ready=1 after the first pop.
- Buffer full, st_valid=1 and mem_wr_ack=1 in the same cycle -> store refused (st_ready=0); count goes 4->3; store accepted on the following cycle.
- Pending entry at word 0x200 with mask 1000; ld_addr=0x201 -> ld_hazard=1; ld_addr=0x204 -> 0; ld_valid=0 -> 0. Incoming store to 0x300 and ld_addr=0x302 in the same cycle -> ld_hazard=1.
- 6 push/pop cycles with continuous ack -> pointers wrap and data order is preserved. Store with mask 0000 -> accepted, count unchanged, no memory write.
- 3 entries held, rst_n pulsed low asynchronously mid-cycle -> mem_wr_en=0, count=0, empty=1 immediately; no writes after reset release.
